// File: rtl/segseq_pkg.sv
// segseq_pkg: shared types and default sizes for the segment sequencer.
//   state_e : sequencer FSM states (IDLE, LOAD, RUN)
//   seg_t   : one segment record (amps/offs/pws banks + duration) at default sizes
//   bank_w  : width of one flattened per-channel parameter bank
package segseq_pkg;

  localparam int unsigned DEF_CHANNELS = 64;
  localparam int unsigned DEF_WORD_W   = 16;
  localparam int unsigned DEF_TIME_W   = 16;
  localparam int unsigned DEF_DEPTH    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_CHANNELS*DEF_WORD_W-1:0] amps;
    logic [DEF_CHANNELS*DEF_WORD_W-1:0] offs;
    logic [DEF_CHANNELS*DEF_WORD_W-1:0] pws;
    logic [DEF_TIME_W-1:0]              seg_time;
  } seg_t;

  function automatic int unsigned bank_w(input int unsigned channels,
                                         input int unsigned word_w);
    return channels * word_w;
  endfunction

endpackage

// File: rtl/segseq_table.sv
// segseq_table: DEPTH-entry segment storage with an append pointer.
//   clk, reset          : clock, async active-high reset (pointer only)
//   clear_i             : drop all entries (pointer back to 0)
//   wr_en_i             : append wr_* at entry seg_count_o (caller guarantees !full_o)
//   wr_amps/offs/pws/time_i : segment being appended
//   rd_idx_i            : read index; rd_* are a direct view of that entry
//   seg_count_o, full_o : registered entry count and count==DEPTH flag
module segseq_table
  import segseq_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
  localparam int unsigned BANK_W  = bank_w(CHANNELS, WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [BANK_W-1:0] wr_amps_i,
  input  logic [BANK_W-1:0] wr_offs_i,
  input  logic [BANK_W-1:0] wr_pws_i,
  input  logic [TIME_W-1:0] wr_time_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [BANK_W-1:0] rd_amps_o,
  output logic [BANK_W-1:0] rd_offs_o,
  output logic [BANK_W-1:0] rd_pws_o,
  output logic [TIME_W-1:0] rd_time_o,
  output logic [CNT_W-1:0]  seg_count_o,
  output logic              full_o
);

  logic [BANK_W-1:0] amps_q [DEPTH];
  logic [BANK_W-1:0] offs_q [DEPTH];
  logic [BANK_W-1:0] pws_q  [DEPTH];
  logic [TIME_W-1:0] time_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic              full_q;

  // Entry storage is deliberately not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      amps_q[IDX_W'(count_q)] <= wr_amps_i;
      offs_q[IDX_W'(count_q)] <= wr_offs_i;
      pws_q[IDX_W'(count_q)]  <= wr_pws_i;
      time_q[IDX_W'(count_q)] <= wr_time_i;
    end
  end

  // Append pointer and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (wr_en_i) begin
      count_q <= count_q + CNT_W'(1);
      full_q  <= (count_q + CNT_W'(1)) == CNT_W'(DEPTH);
    end
  end

  assign rd_amps_o   = amps_q[rd_idx_i];
  assign rd_offs_o   = offs_q[rd_idx_i];
  assign rd_pws_o    = pws_q[rd_idx_i];
  assign rd_time_o   = time_q[rd_idx_i];
  assign seg_count_o = count_q;
  assign full_o      = full_q;

endmodule

// File: rtl/segment_sequencer.sv
// segment_sequencer: plays up to DEPTH committed waveform segments back-to-back
// onto the synthesis bank (clk1 domain).
//   Host side : stg_we/stg_chan/stg_amp/stg_off/stg_pw write the staging bank;
//               commit/commit_time append staging + duration to the table;
//               start/stop/clear control pulses (clear > stop > start > commit).
//   Bank side : act_amps/act_offs/act_pws active parameters (channel c at
//               [c*WORD_W +: WORD_W]), synth_reset on each segment load,
//               synth_active while running.
//   Status    : seg_done, seq_done, commit_err pulses; cur_index, time_left,
//               seg_count, busy, full.
// Build option: define SEGSEQ_LOOP_EN to add the loop input and wrap-to-0 replay.
module segment_sequencer
  import segseq_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned TIME_W   = DEF_TIME_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  localparam int unsigned CH_W    = $clog2(CHANNELS),
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1),
  localparam int unsigned BANK_W  = bank_w(CHANNELS, WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stg_we,
  input  logic [CH_W-1:0]   stg_chan,
  input  logic [WORD_W-1:0] stg_amp,
  input  logic [WORD_W-1:0] stg_off,
  input  logic [WORD_W-1:0] stg_pw,
  input  logic              commit,
  input  logic [TIME_W-1:0] commit_time,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
`ifdef SEGSEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [BANK_W-1:0] act_amps,
  output logic [BANK_W-1:0] act_offs,
  output logic [BANK_W-1:0] act_pws,
  output logic              synth_reset,
  output logic              synth_active,
  output logic              seg_done,
  output logic              seq_done,
  output logic              commit_err,
  output logic [IDX_W-1:0]  cur_index,
  output logic [TIME_W-1:0] time_left,
  output logic [CNT_W-1:0]  seg_count,
  output logic              busy,
  output logic              full
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [TIME_W-1:0] tl_q, tl_d;
  logic [BANK_W-1:0] act_amps_q, act_amps_d;
  logic [BANK_W-1:0] act_offs_q, act_offs_d;
  logic [BANK_W-1:0] act_pws_q, act_pws_d;
  logic              synth_reset_q, synth_reset_d;
  logic              seg_done_q, seg_done_d;
  logic              seq_done_q, seq_done_d;
  logic              commit_err_q, commit_err_d;
  logic              synth_active_q, busy_q;

  logic [BANK_W-1:0] stg_amps_q, stg_offs_q, stg_pws_q;

  logic [BANK_W-1:0] rd_amps, rd_offs, rd_pws;
  logic [TIME_W-1:0] rd_time;
  logic [CNT_W-1:0]  tbl_count;
  logic              tbl_full;
  logic              commit_go, tbl_we;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              loop_en;

`ifdef SEGSEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Commit is the lowest-priority control; a commit into a full table is dropped.
  assign commit_go    = commit && !clear && !stop && !start;
  assign tbl_we       = commit_go && !tbl_full;
  assign commit_err_d = commit_go && tbl_full;
  assign nxt_cnt      = CNT_W'(cur_q) + CNT_W'(1);

  // Staging bank; a same-cycle commit sees the pre-write contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_amps_q <= '0;
      stg_offs_q <= '0;
      stg_pws_q  <= '0;
    end else if (stg_we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (stg_chan == CH_W'(c)) begin
          stg_amps_q[c*WORD_W +: WORD_W] <= stg_amp;
          stg_offs_q[c*WORD_W +: WORD_W] <= stg_off;
          stg_pws_q[c*WORD_W +: WORD_W]  <= stg_pw;
        end
      end
    end
  end

  segseq_table #(
    .CHANNELS(CHANNELS),
    .WORD_W  (WORD_W),
    .TIME_W  (TIME_W),
    .DEPTH   (DEPTH)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .wr_en_i    (tbl_we),
    .wr_amps_i  (stg_amps_q),
    .wr_offs_i  (stg_offs_q),
    .wr_pws_i   (stg_pws_q),
    .wr_time_i  (commit_time),
    .rd_idx_i   (cur_q),
    .rd_amps_o  (rd_amps),
    .rd_offs_o  (rd_offs),
    .rd_pws_o   (rd_pws),
    .rd_time_o  (rd_time),
    .seg_count_o(tbl_count),
    .full_o     (tbl_full)
  );

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    tl_d          = tl_q;
    act_amps_d    = act_amps_q;
    act_offs_d    = act_offs_q;
    act_pws_d     = act_pws_q;
    synth_reset_d = 1'b0;
    seg_done_d    = 1'b0;
    seq_done_d    = 1'b0;
    if (clear || stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (tbl_count != '0)) begin
            state_d = LOAD;
            cur_d   = '0;
          end
        end
        LOAD: begin
          act_amps_d    = rd_amps;
          act_offs_d    = rd_offs;
          act_pws_d     = rd_pws;
          tl_d          = rd_time;
          synth_reset_d = 1'b1;
          state_d       = RUN;
        end
        RUN: begin
          if (tl_q != '0) begin
            tl_d = tl_q - TIME_W'(1);
          end else begin
            seg_done_d = 1'b1;
            // Live count: entries committed while running extend the sequence.
            if (nxt_cnt < tbl_count) begin
              state_d = LOAD;
              cur_d   = cur_q + IDX_W'(1);
            end else if (loop_en) begin
              state_d = LOAD;
              cur_d   = '0;
            end else begin
              seq_done_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      tl_q           <= '0;
      act_amps_q     <= '0;
      act_offs_q     <= '0;
      act_pws_q      <= '0;
      synth_reset_q  <= 1'b0;
      seg_done_q     <= 1'b0;
      seq_done_q     <= 1'b0;
      commit_err_q   <= 1'b0;
      synth_active_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      tl_q           <= tl_d;
      act_amps_q     <= act_amps_d;
      act_offs_q     <= act_offs_d;
      act_pws_q      <= act_pws_d;
      synth_reset_q  <= synth_reset_d;
      seg_done_q     <= seg_done_d;
      seq_done_q     <= seq_done_d;
      commit_err_q   <= commit_err_d;
      synth_active_q <= (state_d == RUN);
      busy_q         <= (state_d != IDLE);
    end
  end

  assign act_amps     = act_amps_q;
  assign act_offs     = act_offs_q;
  assign act_pws      = act_pws_q;
  assign synth_reset  = synth_reset_q;
  assign synth_active = synth_active_q;
  assign seg_done     = seg_done_q;
  assign seq_done     = seq_done_q;
  assign commit_err   = commit_err_q;
  assign cur_index    = cur_q;
  assign time_left    = tl_q;
  assign seg_count    = tbl_count;
  assign busy         = busy_q;
  assign full         = tbl_full;

endmodule

// File: tb/tb_segment_sequencer.sv
// tb_segment_sequencer: directed self-checking bench for segment_sequencer.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_segment_sequencer;

  localparam int unsigned CH = 64;
  localparam int unsigned WW = 16;
  localparam int unsigned TW = 16;
  localparam int unsigned DP = 8;
  localparam int unsigned BW = CH * WW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stg_we = 1'b0;
  logic [5:0]    stg_chan = '0;
  logic [WW-1:0] stg_amp = '0, stg_off = '0, stg_pw = '0;
  logic          commit = 1'b0;
  logic [TW-1:0] commit_time = '0;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0;
`ifdef SEGSEQ_LOOP_EN
  logic          loop = 1'b0;
`endif
  logic [BW-1:0] act_amps, act_offs, act_pws;
  logic          synth_reset, synth_active, seg_done, seq_done, commit_err;
  logic [2:0]    cur_index;
  logic [TW-1:0] time_left;
  logic [3:0]    seg_count;
  logic          busy, full;

  // Bench model of the staging bank.
  logic [BW-1:0] m_amps = '0, m_offs = '0, m_pws = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  segment_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stg_we      (stg_we),
    .stg_chan    (stg_chan),
    .stg_amp     (stg_amp),
    .stg_off     (stg_off),
    .stg_pw      (stg_pw),
    .commit      (commit),
    .commit_time (commit_time),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
`ifdef SEGSEQ_LOOP_EN
    .loop        (loop),
`endif
    .act_amps    (act_amps),
    .act_offs    (act_offs),
    .act_pws     (act_pws),
    .synth_reset (synth_reset),
    .synth_active(synth_active),
    .seg_done    (seg_done),
    .seq_done    (seq_done),
    .commit_err  (commit_err),
    .cur_index   (cur_index),
    .time_left   (time_left),
    .seg_count   (seg_count),
    .busy        (busy),
    .full        (full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stage(input int ch, input logic [WW-1:0] a, input logic [WW-1:0] o,
                       input logic [WW-1:0] p);
    stg_we = 1'b1; stg_chan = 6'(ch); stg_amp = a; stg_off = o; stg_pw = p;
    step();
    stg_we = 1'b0;
    m_amps[ch*WW +: WW] = a; m_offs[ch*WW +: WW] = o; m_pws[ch*WW +: WW] = p;
  endtask

  task automatic commit_seg(input int t);
    commit = 1'b1; commit_time = TW'(t);
    step();
    commit = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({synth_reset, synth_active, seg_done, seq_done, commit_err, busy, full} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {synth_reset, synth_active, seg_done, seq_done, commit_err, busy, full});
    end
    tests_run++;
    if ((act_amps !== '0) || (act_offs !== '0) || (act_pws !== '0)) begin
      tests_failed++;
      $display("FAIL reset_act: act_* not all zero");
    end
    tests_run++;
    if ((cur_index !== 3'd0) || (time_left !== 16'd0) || (seg_count !== 4'd0)) begin
      tests_failed++;
      $display("FAIL reset_counters: cur_index=%0d time_left=%0d seg_count=%0d expected 0/0/0",
               cur_index, time_left, seg_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sequence();
    int sr_cyc[$], sr_idx[$], sd_cyc[$], qd_cyc[$];
    int end_cyc, tl1, tl7;
    do_clear();
    commit_seg(2); commit_seg(0); commit_seg(5);
    tests_run++;
    if (seg_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL seq_count: got %0d expected 3", seg_count);
    end
    start = 1'b1;
    step();                       // cycle 0: LOAD entry 0
    start = 1'b0;
    tests_run++;
    if ((busy !== 1'b1) || (synth_reset !== 1'b0)) begin
      tests_failed++;
      $display("FAIL seq_load0: busy=%b synth_reset=%b expected 1/0", busy, synth_reset);
    end
    end_cyc = -1; tl1 = -1; tl7 = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (synth_reset) begin sr_cyc.push_back(cyc); sr_idx.push_back(int'(cur_index)); end
      if (seg_done) sd_cyc.push_back(cyc);
      if (seq_done) qd_cyc.push_back(cyc);
      if (cyc == 1) tl1 = int'(time_left);
      if (cyc == 7) tl7 = int'(time_left);
      if (!busy) begin end_cyc = cyc; break; end
    end
    tests_run++;
    if (sr_cyc.size() != 3 || sr_cyc[0] != 1 || sr_cyc[1] != 5 || sr_cyc[2] != 7) begin
      tests_failed++;
      $display("FAIL seq_synth_reset: got %p expected '{1, 5, 7}", sr_cyc);
    end
    tests_run++;
    if (sr_idx.size() != 3 || sr_idx[0] != 0 || sr_idx[1] != 1 || sr_idx[2] != 2) begin
      tests_failed++;
      $display("FAIL seq_cur_index: got %p expected '{0, 1, 2}", sr_idx);
    end
    tests_run++;
    if (sd_cyc.size() != 3 || sd_cyc[0] != 4 || sd_cyc[1] != 6 || sd_cyc[2] != 13) begin
      tests_failed++;
      $display("FAIL seq_seg_done: got %p expected '{4, 6, 13}", sd_cyc);
    end
    tests_run++;
    if (qd_cyc.size() != 1 || qd_cyc[0] != 13 || end_cyc != 13) begin
      tests_failed++;
      $display("FAIL seq_seq_done: got %p end=%0d expected '{13} end=13", qd_cyc, end_cyc);
    end
    tests_run++;
    if (tl1 != 2 || tl7 != 5) begin
      tests_failed++;
      $display("FAIL seq_time_left: got %0d/%0d expected 2/5", tl1, tl7);
    end
  endtask

  task automatic test_channel_values();
    logic [BW-1:0] s1_a, s1_o, s1_p, s2_a;
    do_clear();
    stage(5, 16'h1234, 16'h0A0A, 16'h5555);
    stage(0, 16'h0001, 16'h0002, 16'h0003);
    stage(63, 16'hBEEF, 16'h0000, 16'hC0DE);
    s1_a = m_amps; s1_o = m_offs; s1_p = m_pws;
    commit_seg(0);                          // entry 0 = S1
    // same-cycle staging write + commit: entry 1 must be S1
    stg_we = 1'b1; stg_chan = 6'd5; stg_amp = 16'h7777; stg_off = 16'h0A0A; stg_pw = 16'h5555;
    commit = 1'b1; commit_time = 16'd0;
    step();
    stg_we = 1'b0; commit = 1'b0;
    m_amps[5*WW +: WW] = 16'h7777;
    s2_a = m_amps;
    commit_seg(0);                          // entry 2 = S2
    start = 1'b1;
    step();                                 // cycle 0: LOAD entry 0
    start = 1'b0;
    tests_run++;
    if (act_amps !== '0) begin
      tests_failed++;
      $display("FAIL ch_before_load: ch5 amp got %h expected 0000", act_amps[5*WW +: WW]);
    end
    step();                                 // cycle 1
    tests_run++;
    if (act_amps[5*WW +: WW] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL ch5_amp: got %h expected 1234", act_amps[5*WW +: WW]);
    end
    tests_run++;
    if ((act_amps !== s1_a) || (act_offs !== s1_o) || (act_pws !== s1_p)) begin
      tests_failed++;
      $display("FAIL ch_bank_e0: ch0 amp=%h ch63 amp=%h ch5 off=%h expected 0001/beef/0a0a",
               act_amps[0 +: WW], act_amps[63*WW +: WW], act_offs[5*WW +: WW]);
    end
    step(); step();                         // cycle 3: RUN entry 1
    tests_run++;
    if (act_amps !== s1_a) begin
      tests_failed++;
      $display("FAIL ch_precommit_capture: ch5 amp got %h expected 1234", act_amps[5*WW +: WW]);
    end
    step(); step();                         // cycle 5: RUN entry 2
    tests_run++;
    if ((act_amps !== s2_a) || (cur_index !== 3'd2)) begin
      tests_failed++;
      $display("FAIL ch_postwrite: ch5 amp=%h idx=%0d expected 7777/2",
               act_amps[5*WW +: WW], cur_index);
    end
    for (int i = 0; i < 10 && busy; i++) step();
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < DP - 1; i++) commit_seg(0);
    tests_run++;
    if ((full !== 1'b0) || (seg_count !== 4'd7)) begin
      tests_failed++;
      $display("FAIL full_at_7: full=%b count=%0d expected 0/7", full, seg_count);
    end
    commit_seg(0);
    tests_run++;
    if ((full !== 1'b1) || (seg_count !== 4'd8) || (commit_err !== 1'b0)) begin
      tests_failed++;
      $display("FAIL full_at_8: full=%b count=%0d err=%b expected 1/8/0", full, seg_count, commit_err);
    end
    commit_seg(3);
    tests_run++;
    if ((commit_err !== 1'b1) || (seg_count !== 4'd8) || (full !== 1'b1)) begin
      tests_failed++;
      $display("FAIL full_overflow: err=%b count=%0d full=%b expected 1/8/1", commit_err, seg_count, full);
    end
    step();
    tests_run++;
    if (commit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_err_pulse: got %b expected 0", commit_err);
    end
  endtask

  task automatic test_stop();
    int dones;
    do_clear();
    commit_seg(6);
    start = 1'b1;
    step();                                 // cycle 0: LOAD
    start = 1'b0;
    repeat (4) step();                      // cycle 4: time_left 3
    tests_run++;
    if (time_left !== 16'd3) begin
      tests_failed++;
      $display("FAIL stop_precond: time_left got %0d expected 3", time_left);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if ((busy !== 1'b0) || (synth_active !== 1'b0) || (seg_done !== 1'b0) || (seq_done !== 1'b0)) begin
      tests_failed++;
      $display("FAIL stop_idle: busy=%b active=%b seg_done=%b seq_done=%b expected 0000",
               busy, synth_active, seg_done, seq_done);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (seg_done || seq_done) dones++;
    end
    tests_run++;
    if ((dones != 0) || (act_amps !== m_amps) || (act_pws !== m_pws)) begin
      tests_failed++;
      $display("FAIL stop_hold: dones=%0d ch5 amp=%h expected 0/7777", dones, act_amps[5*WW +: WW]);
    end
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests_run++;
    if ((busy !== 1'b0) || (synth_reset !== 1'b0) || (seq_done !== 1'b0)) begin
      tests_failed++;
      $display("FAIL start_empty: busy=%b synth_reset=%b seq_done=%b expected 000",
               busy, synth_reset, seq_done);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    commit_seg(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();                         // RUN, time_left 3
    reset = 1'b1;
    #1;
    tests_run++;
    if ((busy !== 1'b0) || (synth_active !== 1'b0) || (act_amps !== '0) || (act_offs !== '0) ||
        (act_pws !== '0) || (time_left !== 16'd0) || (cur_index !== 3'd0) ||
        (seg_done !== 1'b0) || (seq_done !== 1'b0)) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b active=%b time_left=%0d idx=%0d expected all 0",
               busy, synth_active, time_left, cur_index);
    end
    step();
    reset = 1'b0;
    m_amps = '0; m_offs = '0; m_pws = '0;
    step();
  endtask

`ifdef SEGSEQ_LOOP_EN
  task automatic test_loop();
    int sr_idx[$];
    int qd, end_cyc;
    do_clear();
    commit_seg(1); commit_seg(1);
    loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    qd = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (synth_reset) sr_idx.push_back(int'(cur_index));
      if (seq_done) qd++;
    end
    tests_run++;
    if (sr_idx.size() != 6 || sr_idx[0] != 0 || sr_idx[1] != 1 || sr_idx[2] != 0 ||
        sr_idx[3] != 1 || sr_idx[4] != 0 || sr_idx[5] != 1 || qd != 0) begin
      tests_failed++;
      $display("FAIL loop_order: got %p seq_done=%0d expected '{0, 1, 0, 1, 0, 1} 0", sr_idx, qd);
    end
    loop = 1'b0;                            // cycle 16: entry 1 RUN, time_left 1
    end_cyc = -1;
    for (int cyc = 17; cyc <= 25; cyc++) begin
      step();
      if (seq_done) qd++;
      if (!busy) begin end_cyc = cyc; break; end
    end
    tests_run++;
    if ((end_cyc != 18) || (qd != 1) || (cur_index !== 3'd1)) begin
      tests_failed++;
      $display("FAIL loop_exit: end=%0d seq_done=%0d idx=%0d expected 18/1/1", end_cyc, qd, cur_index);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_channel_values();
    test_full();
    test_stop();
    test_reset_mid();
`ifdef SEGSEQ_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
